// File: rtl/button_conditioner.sv
// Four-channel push-button conditioner: 2-flop synchroniser, per-channel debounce FSM,
// single-cycle press pulse and debounced level for each of Start, Red, Green, Blue.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       SRaw,
    input  logic       RRaw,
    input  logic       GRaw,
    input  logic       BRaw,
    output logic       S,
    output logic       R,
    output logic       G,
    output logic       B,
    output logic [3:0] Pressed
);

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0] raw;
    logic [3:0] pulse_vec;
    logic [3:0] pressed_vec;

    assign raw = {SRaw, RRaw, GRaw, BRaw};

    for (genvar ch = 0; ch < 4; ch++) begin : g_chan
        logic             sync1_q;
        logic             sync2_q;
        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             pulse_q;
        logic             pulse_d;
        logic             pressed_q;
        logic             pressed_d;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            pulse_d   = 1'b0;
            unique case (state_q)
                ST_LO: begin
                    if (sync2_q) begin
                        state_d = CHK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
                CHK_HI: begin
                    if (!sync2_q) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!sync2_q) begin
                        state_d = CHK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
                CHK_LO: begin
                    if (sync2_q) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end
            endcase
            // Level is decoded from the next state so the registered copy tracks state_q exactly.
            pressed_d = (state_d == ST_HI) || (state_d == CHK_LO);
        end

        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                state_q   <= ST_LO;
                cnt_q     <= '0;
                pulse_q   <= 1'b0;
                pressed_q <= 1'b0;
            end else begin
                sync1_q   <= raw[ch];
                sync2_q   <= sync1_q;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                pulse_q   <= pulse_d;
                pressed_q <= pressed_d;
            end
        end

        assign pulse_vec[ch]   = pulse_q;
        assign pressed_vec[ch] = pressed_q;
    end

    assign S       = pulse_vec[3];
    assign R       = pulse_vec[2];
    assign G       = pulse_vec[1];
    assign B       = pulse_vec[0];
    assign Pressed = pressed_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: per-cycle scoreboard against a run-length
// debounce model, plus fixed-latency and pulse-count checks for each scenario.
module tb_button_conditioner;

    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       SRaw = 1'b0;
    logic       RRaw = 1'b0;
    logic       GRaw = 1'b0;
    logic       BRaw = 1'b0;
    logic       S;
    logic       R;
    logic       G;
    logic       B;
    logic [3:0] Pressed;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .SRaw   (SRaw),
        .RRaw   (RRaw),
        .GRaw   (GRaw),
        .BRaw   (BRaw),
        .S      (S),
        .R      (R),
        .G      (G),
        .B      (B),
        .Pressed(Pressed)
    );

    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];

    // Model: debounced level flips after D consecutive synchronised samples that disagree with it.
    logic [3:0] m_s1, m_s2, m_lvl, m_pulse;
    int         m_run[4];

    int ph_edge;
    int first_pulse[4];
    int pulse_cnt[4];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
        for (int c = 0; c < 4; c++) m_run[c] = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw_v);
        if (!Rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_pulse[c] = 1'b0;
                if (m_s2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_lvl[c]   = m_s2[c];
                        m_run[c]   = 0;
                        m_pulse[c] = m_s2[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw_v;
        end
    endtask

    task automatic new_phase();
        ph_edge = 0;
        for (int c = 0; c < 4; c++) begin
            first_pulse[c] = -1;
            pulse_cnt[c]   = 0;
        end
    endtask

    // raw_v bit order {S,R,G,B}; applied before the edge, sampled #1 after it.
    task automatic tick(input logic [3:0] raw_v);
        logic [7:0] obs;
        logic [7:0] exp;
        {SRaw, RRaw, GRaw, BRaw} = raw_v;
        @(posedge Clk);
        model_edge(raw_v);
        exp_q.push_back({m_pulse, m_lvl});
        #1;
        obs = {S, R, G, B, Pressed};
        exp = exp_q.pop_front();
        check("cycle", obs, exp);
        for (int c = 0; c < 4; c++) begin
            if (obs[4+c]) begin
                pulse_cnt[c]++;
                if (first_pulse[c] < 0) first_pulse[c] = ph_edge;
            end
        end
        ph_edge++;
    endtask

    task automatic ticks(input logic [3:0] raw_v, input int n);
        for (int k = 0; k < n; k++) tick(raw_v);
    endtask

    initial begin
        model_reset();
        new_phase();

        // Power-on reset: outputs cleared asynchronously
        #2 Rst = 1'b0;
        #1 check("reset_async", {S, R, G, B, Pressed}, 8'h00);
        ticks(4'b0000, 2);
        Rst = 1'b1;
        ticks(4'b0000, 4);

        // Clean press on R
        new_phase();
        ticks(4'b0100, 20);
        check_int("clean_r_edge", first_pulse[2], 5);
        check_int("clean_r_count", pulse_cnt[2], 1);
        check_int("clean_others", pulse_cnt[3] + pulse_cnt[1] + pulse_cnt[0], 0);
        check("clean_pressed", {4'h0, Pressed}, 8'h04);
        ticks(4'b0000, 10);

        // Bounce on press, G
        new_phase();
        tick(4'b0010); tick(4'b0010); tick(4'b0000);
        tick(4'b0010); tick(4'b0010); tick(4'b0000);
        ticks(4'b0010, 15);
        check_int("bounce_g_edge", first_pulse[1], 11);
        check_int("bounce_g_count", pulse_cnt[1], 1);
        ticks(4'b0000, 10);

        // Release bounce, B
        new_phase();
        ticks(4'b0001, 12);
        ticks(4'b0000, 3); ticks(4'b0001, 3);
        ticks(4'b0000, 3); ticks(4'b0001, 3);
        ticks(4'b0000, 12);
        check_int("release_b_count", pulse_cnt[0], 1);
        check("release_pressed", {4'h0, Pressed}, 8'h00);

        // Simultaneous R and G
        new_phase();
        ticks(4'b0110, 12);
        check_int("simul_r_edge", first_pulse[2], 5);
        check_int("simul_g_edge", first_pulse[1], 5);
        check_int("simul_counts", pulse_cnt[2] + pulse_cnt[1], 2);
        ticks(4'b0000, 10);

        // Reset while S pulse is in flight
        new_phase();
        ticks(4'b1000, 6);
        check("s_pulse_before_rst", {S, R, G, B, Pressed}, 8'h88);
        Rst = 1'b0;
        #1 check("rst_mid_pulse", {S, R, G, B, Pressed}, 8'h00);
        model_reset();
        ticks(4'b1000, 2);
        Rst = 1'b1;
        new_phase();
        ticks(4'b1000, 12);
        check_int("rst_release_s_edge", first_pulse[3], 5);
        check_int("rst_release_s_count", pulse_cnt[3], 1);
        ticks(4'b0000, 10);

        // Repeated presses on B
        new_phase();
        for (int k = 0; k < 3; k++) begin
            ticks(4'b0001, 10);
            ticks(4'b0000, 10);
        end
        check_int("repeat_b_count", pulse_cnt[0], 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
